// File: rtl/count_step_sequencer_if.sv
// Target handshake bundle for count_step_sequencer: the master offers a
// target count and the sequencer (slave) signals when it can take one.
interface count_step_sequencer_if #(
    parameter int WIDTH = 8
) ();
    logic             tgt_valid;
    logic             tgt_ready;
    logic [WIDTH-1:0] tgt_data;

    modport master (
        output tgt_valid,
        output tgt_data,
        input  tgt_ready
    );

    modport slave (
        input  tgt_valid,
        input  tgt_data,
        output tgt_ready
    );
endinterface

// File: rtl/count_step_sequencer.sv
// Steps an external up/down counter toward a requested target, tracks its value
// and checks c_out. Define COUNT_SEQ_SHORTEST_PATH_EN for modulo (wrapping) direction choice.
module count_step_sequencer #(
    parameter int WIDTH = 8,
    parameter int GAP   = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    count_step_sequencer_if.slave tgt,
    input  logic                 abort,
    output logic                 up,
    output logic                 down,
    output logic                 en,
    input  logic                 c_out,
    output logic                 busy,
    output logic                 done,
    output logic [WIDTH-1:0]     shadow,
    output logic                 err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_STEP = 2'd1,
        ST_HOLD = 2'd2,
        ST_FIN  = 2'd3
    } state_t;

    localparam int                HOLD_W    = (GAP > 2) ? $clog2(GAP) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(GAP - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(1);
    localparam logic [WIDTH-1:0]  ONE       = {{(WIDTH-1){1'b0}}, 1'b1};
`ifdef COUNT_SEQ_SHORTEST_PATH_EN
    localparam logic [WIDTH-1:0]  HALF      = {1'b1, {(WIDTH-1){1'b0}}};
`endif

    state_t              state_r;
    state_t              state_s;
    logic [WIDTH-1:0]    shadow_r;
    logic [WIDTH-1:0]    shadow_s;
    logic [WIDTH-1:0]    target_r;
    logic [WIDTH-1:0]    target_s;
    logic [HOLD_W-1:0]   hold_cnt_r;
    logic [HOLD_W-1:0]   hold_cnt_s;
    logic                dir_up_s;
    logic                step_wrap_s;
    logic                mismatch_s;
    logic                up_r;
    logic                down_r;
    logic                en_r;
    logic                busy_r;
    logic                done_r;
    logic                ready_r;
    logic                err_r;
    logic                chk_pend_r;
    logic                exp_carry_r;

    // A step wraps when counting up from all-ones or down from zero.
    function automatic logic step_wraps(input logic [WIDTH-1:0] cur, input logic going_up);
        logic wraps;
        if (going_up) begin
            wraps = &cur;
        end else begin
            wraps = ~|cur;
        end
        return wraps;
    endfunction

    // Direction of the next step; the wrapping variant takes the shorter way round, ties go up.
    function automatic logic pick_up(input logic [WIDTH-1:0] tgt_v, input logic [WIDTH-1:0] cur_v);
`ifdef COUNT_SEQ_SHORTEST_PATH_EN
        logic [WIDTH-1:0] dist;
        dist = tgt_v - cur_v;
        return (dist <= HALF);
`else
        return (tgt_v > cur_v);
`endif
    endfunction

    // Next-state, shadow update and carry-mismatch detection.
    always_comb begin
        state_s     = state_r;
        target_s    = target_r;
        hold_cnt_s  = hold_cnt_r;
        shadow_s    = shadow_r;
        step_wrap_s = 1'b0;

        if (state_r == ST_STEP) begin
            step_wrap_s = step_wraps(shadow_r, up_r);
            if (up_r) begin
                shadow_s = shadow_r + ONE;
            end else begin
                shadow_s = shadow_r - ONE;
            end
        end else begin
            shadow_s = shadow_r;
        end

        case (state_r)
            ST_IDLE: begin
                if (tgt.tgt_valid) begin
                    target_s = tgt.tgt_data;
                    if (tgt.tgt_data == shadow_r) begin
                        state_s = ST_FIN;
                    end else begin
                        state_s = ST_STEP;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_STEP: begin
                // Abort wins over reaching the target: no done pulse after an abort.
                if (abort) begin
                    state_s = ST_IDLE;
                end else if (shadow_s == target_r) begin
                    state_s = ST_FIN;
                end else if (GAP == 1) begin
                    state_s = ST_STEP;
                end else begin
                    state_s    = ST_HOLD;
                    hold_cnt_s = HOLD_LOAD;
                end
            end
            ST_HOLD: begin
                if (abort) begin
                    state_s = ST_IDLE;
                end else if (hold_cnt_r == HOLD_LAST) begin
                    state_s = ST_STEP;
                end else begin
                    hold_cnt_s = hold_cnt_r - HOLD_LAST;
                end
            end
            ST_FIN: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase

        dir_up_s   = pick_up(target_s, shadow_s);
        mismatch_s = chk_pend_r & (c_out != exp_carry_r);
    end

    // State, shadow and registered command outputs decoded from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            shadow_r   <= {WIDTH{1'b0}};
            target_r   <= {WIDTH{1'b0}};
            hold_cnt_r <= {HOLD_W{1'b0}};
            up_r       <= 1'b0;
            down_r     <= 1'b0;
            en_r       <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            ready_r    <= 1'b1;
        end else begin
            state_r    <= state_s;
            shadow_r   <= shadow_s;
            target_r   <= target_s;
            hold_cnt_r <= hold_cnt_s;
            up_r       <= (state_s == ST_STEP) &  dir_up_s;
            down_r     <= (state_s == ST_STEP) & ~dir_up_s;
            en_r       <= (state_s == ST_STEP);
            busy_r     <= (state_s != ST_IDLE);
            done_r     <= (state_s == ST_FIN);
            ready_r    <= (state_s == ST_IDLE);
        end
    end

    // c_out is only judged in the cycle right after a step; err is sticky until reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            chk_pend_r  <= 1'b0;
            exp_carry_r <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            chk_pend_r  <= (state_r == ST_STEP);
            exp_carry_r <= step_wrap_s;
            err_r       <= err_r | mismatch_s;
        end
    end

    assign tgt.tgt_ready = ready_r;
    assign up            = up_r;
    assign down          = down_r;
    assign en            = en_r;
    assign busy          = busy_r;
    assign done          = done_r;
    assign shadow        = shadow_r;
    assign err           = err_r;

endmodule

// File: tb/tb_count_step_sequencer.sv
// Bench for count_step_sequencer: two instances (GAP=1 and GAP=3) driven from a
// directed table, hand-written reset sequence and random targets against a trace model.
module tb_count_step_sequencer;

    localparam int WIDTH = 8;
    localparam int GAP0  = 1;
    localparam int GAP1  = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    count_step_sequencer_if #(.WIDTH(WIDTH)) if0 ();
    count_step_sequencer_if #(.WIDTH(WIDTH)) if1 ();

    logic       tv [2];
    logic [7:0] td [2];
    logic       ab [2];
    logic       co [2];
    logic       up0, down0, en0, busy0, done0, err0;
    logic       up1, down1, en1, busy1, done1, err1;
    logic [7:0] sh0, sh1;

    assign if0.tgt_valid = tv[0];
    assign if0.tgt_data  = td[0];
    assign if1.tgt_valid = tv[1];
    assign if1.tgt_data  = td[1];

    count_step_sequencer #(.WIDTH(WIDTH), .GAP(GAP0)) dut0 (
        .clk(clk), .rst(rst), .tgt(if0.slave), .abort(ab[0]),
        .up(up0), .down(down0), .en(en0), .c_out(co[0]),
        .busy(busy0), .done(done0), .shadow(sh0), .err(err0)
    );

    count_step_sequencer #(.WIDTH(WIDTH), .GAP(GAP1)) dut1 (
        .clk(clk), .rst(rst), .tgt(if1.slave), .abort(ab[1]),
        .up(up1), .down(down1), .en(en1), .c_out(co[1]),
        .busy(busy1), .done(done1), .shadow(sh1), .err(err1)
    );

    typedef struct packed {
        logic       ready;
        logic       busy;
        logic       en;
        logic       up;
        logic       down;
        logic       done;
        logic       err;
        logic [7:0] shadow;
    } obs_t;

    obs_t obs [2];
    assign obs[0] = {if0.tgt_ready, busy0, en0, up0, down0, done0, err0, sh0};
    assign obs[1] = {if1.tgt_ready, busy1, en1, up1, down1, done1, err1, sh1};

    typedef struct {
        int         k;
        logic [7:0] tgt;
        int         abort_step;
        bit         bad;
        bit         hold_valid;
        logic [7:0] exp_shadow;
        bit         exp_err;
    } vec_t;

    logic [7:0] m_shadow [2];
    logic       m_err    [2];
    int         n_checks = 0;
    int         n_fail   = 0;

    function automatic obs_t mk(input logic r, input logic b, input logic e, input logic u,
                                input logic d, input logic dn, input logic er, input logic [7:0] s);
        obs_t o;
        o.ready = r; o.busy = b; o.en = e; o.up = u; o.down = d;
        o.done = dn; o.err = er; o.shadow = s;
        return o;
    endfunction

    task automatic check(input string name, input obs_t act, input obs_t exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got rdy=%b busy=%b en=%b up=%b dn=%b done=%b err=%b sh=%h, expected rdy=%b busy=%b en=%b up=%b dn=%b done=%b err=%b sh=%h",
                     name, $time, act.ready, act.busy, act.en, act.up, act.down, act.done, act.err, act.shadow,
                     exp.ready, exp.busy, exp.en, exp.up, exp.down, exp.done, exp.err, exp.shadow);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %b, expected %b", name, $time, act, exp);
        end
    endtask

    task automatic check_byte(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // Inputs already driven; compare on the falling edge, then advance past the next rising edge.
    task automatic cycle(input int k, input string name, input obs_t exp);
        @(negedge clk);
        check(name, obs[k], exp);
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycles(input int k, input int n);
        for (int i = 0; i < n; i++) begin
            tv[k] = 1'b0;
            ab[k] = 1'b0;
            co[k] = 1'($urandom_range(0, 1));
            cycle(k, "idle", mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, m_err[k], m_shadow[k]));
        end
    endtask

    // Plans the whole expected cycle trace arithmetically, then offers the target and walks it.
    task automatic run_target(input int k, input logic [7:0] t, input int abort_req,
                              input bit bad, input bit hold_valid);
        obs_t       tr [$];
        bit         is_st [$];
        bit         wr [$];
        logic [7:0] s, cur, d;
        bit         dir_up, any_wrap, flip_done, prev_st, prev_wr, err_next;
        int         n, steps, gap, ab_idx;
        obs_t       e;

        gap = (k == 0) ? GAP0 : GAP1;
        s   = m_shadow[k];
        d   = t - s;
`ifdef COUNT_SEQ_SHORTEST_PATH_EN
        dir_up = (d <= 8'h80);
`else
        dir_up = (t > s);
`endif
        if (d == 8'h00)  n = 0;
        else if (dir_up) n = int'(d);
        else             n = 256 - int'(d);
        if (abort_req < 1 || abort_req > n) abort_req = 0;
        steps    = (abort_req != 0) ? abort_req : n;
        cur      = s;
        any_wrap = 1'b0;

        for (int i = 0; i < steps; i++) begin
            tr.push_back(mk(1'b0, 1'b1, 1'b1, dir_up, !dir_up, 1'b0, 1'b0, cur));
            is_st.push_back(1'b1);
            wr.push_back(dir_up ? (cur == 8'hFF) : (cur == 8'h00));
            any_wrap = any_wrap | wr[wr.size()-1];
            cur = dir_up ? cur + 8'h01 : cur - 8'h01;
            if (i < steps - 1) begin
                for (int h = 0; h < gap - 1; h++) begin
                    tr.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, cur));
                    is_st.push_back(1'b0);
                    wr.push_back(1'b0);
                end
            end
        end
        if (abort_req == 0) begin
            tr.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, cur));
            is_st.push_back(1'b0);
            wr.push_back(1'b0);
        end
        tr.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, cur));
        is_st.push_back(1'b0);
        wr.push_back(1'b0);
        ab_idx = (abort_req != 0) ? tr.size() - 2 : -1;

        tv[k] = 1'b1;
        td[k] = t;
        ab[k] = 1'b0;
        co[k] = 1'($urandom_range(0, 1));
        cycle(k, "offer", mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, m_err[k], s));

        prev_st   = 1'b0;
        prev_wr   = 1'b0;
        flip_done = 1'b0;
        for (int j = 0; j < tr.size(); j++) begin
            tv[k] = (j == tr.size() - 1) ? 1'b0 : hold_valid;
            td[k] = ~t;
            ab[k] = (j == ab_idx);
            err_next = 1'b0;
            if (prev_st) begin
                co[k] = prev_wr;
                if (bad && !flip_done && (prev_wr || !any_wrap)) begin
                    co[k]     = !prev_wr;
                    flip_done = 1'b1;
                    err_next  = 1'b1;
                end
            end else begin
                co[k] = 1'($urandom_range(0, 1));
            end
            e     = tr[j];
            e.err = m_err[k];
            cycle(k, "trace", e);
            if (err_next) m_err[k] = 1'b1;
            prev_st = is_st[j];
            prev_wr = wr[j];
        end
        ab[k]       = 1'b0;
        m_shadow[k] = cur;
    endtask

    initial begin
        vec_t vecs [$];
        int   k;

        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tv[i] = 1'b0; td[i] = 8'h00; ab[i] = 1'b0; co[i] = 1'b0;
            m_shadow[i] = 8'h00; m_err[i] = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset0", obs[0], mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00));
        check("reset1", obs[1], mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00));
        idle_cycles(0, 1);

        vecs.push_back('{0, 8'h03, 0, 1'b0, 1'b0, 8'h03, 1'b0});
        vecs.push_back('{1, 8'h03, 0, 1'b0, 1'b0, 8'h03, 1'b0});
        vecs.push_back('{1, 8'h01, 0, 1'b0, 1'b1, 8'h01, 1'b0});
        vecs.push_back('{1, 8'h01, 0, 1'b0, 1'b0, 8'h01, 1'b0});
        vecs.push_back('{1, 8'h10, 3, 1'b0, 1'b0, 8'h04, 1'b0});
        vecs.push_back('{1, 8'h02, 0, 1'b0, 1'b0, 8'h02, 1'b0});
`ifdef COUNT_SEQ_SHORTEST_PATH_EN
        vecs.push_back('{0, 8'h02, 0, 1'b0, 1'b0, 8'h02, 1'b0});
        vecs.push_back('{0, 8'hFE, 0, 1'b0, 1'b0, 8'hFE, 1'b0});
        vecs.push_back('{0, 8'h02, 0, 1'b0, 1'b0, 8'h02, 1'b0});
        vecs.push_back('{0, 8'hFE, 0, 1'b1, 1'b0, 8'hFE, 1'b1});
        vecs.push_back('{0, 8'h00, 0, 1'b0, 1'b0, 8'h00, 1'b1});
`else
        vecs.push_back('{0, 8'h05, 0, 1'b1, 1'b0, 8'h05, 1'b1});
        vecs.push_back('{0, 8'h04, 0, 1'b0, 1'b1, 8'h04, 1'b1});
`endif

        foreach (vecs[i]) begin
            run_target(vecs[i].k, vecs[i].tgt, vecs[i].abort_step, vecs[i].bad, vecs[i].hold_valid);
            check_byte("vec_shadow", obs[vecs[i].k].shadow, vecs[i].exp_shadow);
            check_bit("vec_err", obs[vecs[i].k].err, vecs[i].exp_err);
            idle_cycles(vecs[i].k, 2);
        end

        // Random targets, occasional aborts and valid held high during sequences.
        for (int r = 0; r < 30; r++) begin
            k = int'($urandom_range(0, 1));
            idle_cycles(k, int'($urandom_range(0, 2)));
            run_target(k, 8'($urandom),
                       ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 6)) : 0,
                       1'b0, 1'($urandom_range(0, 1)));
        end

        // Reset in the middle of a sequence: straight back to reset state, no done.
        idle_cycles(1, 1);
        tv[1] = 1'b1;
        td[1] = m_shadow[1] + 8'h40;
        @(posedge clk);
        #1;
        tv[1] = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check_bit("busy_mid", obs[1].busy, 1'b1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            m_shadow[i] = 8'h00;
            m_err[i]    = 1'b0;
        end
        check("rst_mid1", obs[1], mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00));
        check("rst_mid0", obs[0], mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00));
        idle_cycles(1, 3);
        run_target(1, 8'h02, 0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
